// File: rtl/robo_aspirador_ctrl.sv
// Vacuum-robot motion controller: synchronises and debounces the bump
// sensors, runs timed reverse/turn escape manoeuvres from a Moore FSM,
// handles low battery with a pulsed buzzer and counts collisions.
module robo_aspirador_ctrl #(
    parameter int DEB    = 3,
    parameter int T_RE   = 8,
    parameter int T_GIRO = 12,
    parameter int T_BIP  = 4,
    parameter int W_COL  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             liga,
    input  logic             f,
    input  logic             a,
    input  logic             d,
    input  logic             e,
    input  logic             bateria,
    output logic [1:0]       saida_e,
    output logic [1:0]       saida_d,
    output logic             sbuzzer,
    output logic             rgbverde,
    output logic             rgbverm,
    output logic             rgbazul,
    output logic [W_COL-1:0] colisoes
);

    localparam int T_MAX = (T_RE > T_GIRO) ? ((T_RE > T_BIP) ? T_RE : T_BIP)
                                           : ((T_GIRO > T_BIP) ? T_GIRO : T_BIP);
    localparam int TW = $clog2(T_MAX + 1);
    localparam int CW = $clog2(DEB + 1);

    localparam logic [TW-1:0] LD_RE   = TW'(T_RE - 1);
    localparam logic [TW-1:0] LD_GIRO = TW'(T_GIRO - 1);
    localparam logic [TW-1:0] LD_BIP  = TW'(T_BIP - 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB);

    localparam logic [1:0] M_STOP   = 2'b00;
    localparam logic [1:0] M_FRENTE = 2'b01;
    localparam logic [1:0] M_RE     = 2'b10;

    typedef enum logic [2:0] {
        PARADO, FRENTE, RE, GIRO_E, GIRO_D, BAT_BAIXA
    } state_t;

    // Synchronised bits: [5]=liga [4]=bateria [3]=f [2]=a [1]=d [0]=e
    logic [5:0]    sync_q1, sync_q2;
    logic [CW-1:0] deb_cnt [4];
    logic [3:0]    bump_db;
    logic          liga_s, bat_s;

    state_t        state, state_nx;
    logic          toggle, toggle_nx;
    logic          col_inc;
    logic [TW-1:0] timer;

    assign liga_s = sync_q2[5];
    assign bat_s  = sync_q2[4];

    // Two-flop synchroniser for all asynchronous inputs.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would collapse the two stages.
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {liga, bateria, f, a, d, e};
            sync_q2 <= sync_q1;
        end
    end

    // Debounce counters: count consecutive synchronised highs, saturate at DEB.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n || !sync_q2[i]) begin
                deb_cnt[i] <= '0;
            end else if (deb_cnt[i] != DEB_MAX) begin
                deb_cnt[i] <= deb_cnt[i] + CW'(1);
            end
        end
    end

    // A bump counts as asserted only once its counter has saturated.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bump_db[i] = (deb_cnt[i] == DEB_MAX);
        end
    end

    // Next-state logic: liga and bateria override every state-specific rule.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_nx  = state;
        toggle_nx = toggle;
        col_inc   = 1'b0;
        if (!liga_s) begin
            state_nx = PARADO;
        end else if (bat_s) begin
            state_nx = BAT_BAIXA;
        end else begin
            case (state)
                PARADO: state_nx = FRENTE;
                FRENTE: begin
                    if (bump_db[3]) begin
                        state_nx = RE;
                        col_inc  = 1'b1;
                    end else if (bump_db[1]) begin
                        state_nx = GIRO_E;
                        col_inc  = 1'b1;
                    end else if (bump_db[0]) begin
                        state_nx = GIRO_D;
                        col_inc  = 1'b1;
                    end
                end
                RE: begin
                    if (timer == '0 || bump_db[2]) begin
                        if (bump_db[1]) begin
                            state_nx = GIRO_E;
                        end else if (bump_db[0]) begin
                            state_nx = GIRO_D;
                        end else begin
                            // No side hint: alternate turn direction.
                            state_nx  = toggle ? GIRO_E : GIRO_D;
                            toggle_nx = ~toggle;
                        end
                    end
                end
                GIRO_E, GIRO_D: begin
                    if (timer == '0) state_nx = FRENTE;
                end
                BAT_BAIXA: state_nx = PARADO;
                default:   state_nx = PARADO;
            endcase
        end
    end

    // State, manoeuvre timer, collision counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PARADO;
            toggle   <= 1'b0;
            timer    <= '0;
            colisoes <= '0;
            saida_e  <= M_STOP;
            saida_d  <= M_STOP;
            sbuzzer  <= 1'b0;
            rgbverde <= 1'b0;
            rgbverm  <= 1'b0;
            rgbazul  <= 1'b0;
        end else begin
            state  <= state_nx;
            toggle <= toggle_nx;

            if (col_inc && colisoes != '1) colisoes <= colisoes + 1'b1;

            // The timer reloads on every state entry; in BAT_BAIXA it also
            // reloads on expiry to pace the buzzer.
            if (state_nx != state) begin
                case (state_nx)
                    RE:             timer <= LD_RE;
                    GIRO_E, GIRO_D: timer <= LD_GIRO;
                    BAT_BAIXA:      timer <= LD_BIP;
                    default:        timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end else if (state == BAT_BAIXA) begin
                timer <= LD_BIP;
            end

            if (state_nx == BAT_BAIXA) begin
                if (state != BAT_BAIXA)  sbuzzer <= 1'b1;
                else if (timer == '0)    sbuzzer <= ~sbuzzer;
            end else begin
                sbuzzer <= 1'b0;
            end

            saida_e  <= M_STOP;
            saida_d  <= M_STOP;
            rgbverde <= 1'b0;
            rgbverm  <= 1'b0;
            rgbazul  <= 1'b0;
            case (state_nx)
                FRENTE: begin
                    saida_e  <= M_FRENTE;
                    saida_d  <= M_FRENTE;
                    rgbverde <= 1'b1;
                end
                RE: begin
                    saida_e <= M_RE;
                    saida_d <= M_RE;
                    rgbverm <= 1'b1;
                    rgbazul <= 1'b1;
                end
                GIRO_E: begin
                    saida_e <= M_RE;
                    saida_d <= M_FRENTE;
                    rgbverm <= 1'b1;
                end
                GIRO_D: begin
                    saida_e <= M_FRENTE;
                    saida_d <= M_RE;
                    rgbazul <= 1'b1;
                end
                BAT_BAIXA: rgbverm <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
